mem_port_arbiter: RTL

- Shares the single external memory port between I-cache refill and D-cache miss/writeback traffic, with one outstanding transaction at a time.
- Sits below both caches. The I-cache side serves the fetch stage.
- A fetch redirect (branch taken) can cancel or discard an in-flight I-cache refill so that stale lines never reach the I-cache.
- D-cache has fixed priority, bounded by a starvation counter that guarantees I-cache forward progress.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and widths for the memory port arbiter
package mem_port_arbiter_pkg;

  // One cache line carries four 32-bit instructions.
  localparam int MEM_LINE_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    ICACHE = 2'd1,
    DCACHE = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding memory port shared by I-cache refill and D-cache traffic
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = MEM_LINE_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Icache2arb_req,
  input  logic [ADDR_WIDTH-1:0] Icache2arb_addr,
  input  logic                  Icache_flush,
  output logic                  arb2Icache_resp_valid,
  output logic [LINE_WIDTH-1:0] arb2Icache_resp_data,
  input  logic                  Dcache2arb_req,
  input  logic                  Dcache2arb_we,
  input  logic [ADDR_WIDTH-1:0] Dcache2arb_addr,
  input  logic [LINE_WIDTH-1:0] Dcache2arb_wdata,
  output logic                  arb2Dcache_resp_valid,
  output logic [LINE_WIDTH-1:0] arb2Dcache_resp_data,
  output logic                  arb2mem_req_valid,
  input  logic                  mem2arb_req_ready,
  output logic [ADDR_WIDTH-1:0] arb2mem_addr,
  output logic                  arb2mem_we,
  output logic [LINE_WIDTH-1:0] arb2mem_wdata,
  input  logic                  mem2arb_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem2arb_resp_data,
  output logic                  arb_busy
);

  localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t            state, state_n;
  arb_owner_t            owner, owner_n;
  logic                  drop, drop_n;
  logic [CNT_W-1:0]      starve_cnt, starve_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic icache_elig, dcache_win, icache_win, resp_fire, icache_flush_hit;

  // Grant qualification: D-cache wins unless it has starved a waiting I-cache long enough
  always_comb begin
    icache_elig      = Icache2arb_req & ~Icache_flush;
    dcache_win       = Dcache2arb_req & ((starve_cnt < LIMIT) | ~icache_elig);
    icache_win       = icache_elig & ~dcache_win;
    resp_fire        = (state == WAIT) & mem2arb_resp_valid;
    icache_flush_hit = (owner == ICACHE) & Icache_flush;
  end

  // Next-state, ownership, drop flag and starvation counter
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    drop_n   = drop;
    starve_n = starve_cnt;
    case (state)
      IDLE: begin
        if (dcache_win) begin
          state_n = ISSUE;
          owner_n = DCACHE;
          if (icache_elig && (starve_cnt < LIMIT)) starve_n = starve_cnt + CNT_W'(1);
        end else if (icache_win) begin
          state_n  = ISSUE;
          owner_n  = ICACHE;
          starve_n = '0;
        end
      end
      ISSUE: begin
        if (mem2arb_req_ready) begin
          // Request already accepted: the refill still returns, but must be discarded.
          state_n = WAIT;
          if (icache_flush_hit) drop_n = 1'b1;
        end else if (icache_flush_hit) begin
          state_n = IDLE;
          owner_n = NONE;
        end
      end
      WAIT: begin
        if (icache_flush_hit) drop_n = 1'b1;
        if (mem2arb_resp_valid) begin
          state_n = IDLE;
          owner_n = NONE;
          drop_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        owner_n = NONE;
        drop_n  = 1'b0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= NONE;
      drop       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      drop       <= drop_n;
      starve_cnt <= starve_n;
    end
  end

  // Capture the winner's request fields at grant time
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state == IDLE) begin
      if (dcache_win) begin
        addr_q  <= Dcache2arb_addr;
        we_q    <= Dcache2arb_we;
        wdata_q <= Dcache2arb_wdata;
      end else if (icache_win) begin
        addr_q  <= Icache2arb_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  // Memory-side request and same-cycle response forwarding to the owning cache
  always_comb begin
    arb2mem_req_valid     = (state == ISSUE);
    arb2mem_addr          = addr_q;
    arb2mem_we            = we_q;
    arb2mem_wdata         = wdata_q;
    arb_busy              = (state != IDLE);
    arb2Icache_resp_valid = resp_fire & (owner == ICACHE) & ~drop & ~Icache_flush;
    arb2Dcache_resp_valid = resp_fire & (owner == DCACHE);
    arb2Icache_resp_data  = arb2Icache_resp_valid ? mem2arb_resp_data : '0;
    arb2Dcache_resp_data  = arb2Dcache_resp_valid ? mem2arb_resp_data : '0;
  end

endmodule
